// File: rtl/dynamic_bus_sequencer_pkg.sv
// Shared definitions for the dynamic bus sequencer: phase encoding, counter widths
// and the saturating increment used by the completed-cycle counter.
package dynamic_bus_sequencer_pkg;

    localparam int PRE_CNT_W   = 4;
    localparam int DECAY_CNT_W = 8;
    localparam int CYCLE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRECHARGE = 2'd1,
        ST_DISCHARGE = 2'd2,
        ST_SAMPLE    = 2'd3
    } bus_state_e;

    function automatic logic [CYCLE_CNT_W-1:0] sat_inc(input logic [CYCLE_CNT_W-1:0] value);
        return (value == {CYCLE_CNT_W{1'b1}}) ? value : value + CYCLE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dynamic_bus_sequencer_wired_and.sv
// Wired-AND merge of the pull-down sources: a line reads low if any enabled
// source pulls it; also flags when more than one source is enabled.
module wired_and_resolver #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4
) (
    input  logic [NSRC-1:0]       pd_en_i,
    input  logic [NSRC*WIDTH-1:0] pd_mask_i,
    output logic [WIDTH-1:0]      bus_value_o,
    output logic                  multi_driver_o
);

    logic [WIDTH-1:0] gated_mask [NSRC];
    logic [WIDTH-1:0] pulled;
    logic             seen_any;
    logic             seen_multi;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign gated_mask[gi] = pd_en_i[gi] ? pd_mask_i[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        pulled     = '0;
        seen_any   = 1'b0;
        seen_multi = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            pulled = pulled | gated_mask[i];
            if (pd_en_i[i]) begin
                seen_multi = seen_multi | seen_any;
                seen_any   = 1'b1;
            end
        end
    end

    assign bus_value_o    = ~pulled;
    assign multi_driver_o = seen_multi;

endmodule

// File: rtl/dynamic_bus_sequencer.sv
// Precharge/discharge bus cycle sequencer with stall-driven charge decay,
// registered sample results and a saturating completed-cycle counter.
module dynamic_bus_sequencer
    import dynamic_bus_sequencer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NSRC         = 4,
    parameter int PRE_CYCLES   = 1,
    parameter int DECAY_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   stall,
    input  logic [NSRC-1:0]        pd_en,
    input  logic [NSRC*WIDTH-1:0]  pd_mask,
    output logic [WIDTH-1:0]       bus,
    output logic [1:0]             phase,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid,
    output logic                   contention,
    output logic                   decayed,
    output logic [CYCLE_CNT_W-1:0] cycle_count
);

    localparam logic [PRE_CNT_W-1:0]   PRE_LAST   = PRE_CNT_W'(PRE_CYCLES - 1);
    localparam logic [DECAY_CNT_W-1:0] DECAY_LAST = DECAY_CNT_W'(DECAY_CYCLES - 1);

    bus_state_e             state_q, state_d;
    logic [PRE_CNT_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [DECAY_CNT_W-1:0] decay_cnt_q, decay_cnt_d;
    logic                   decay_hit_q, decay_hit_d;
    logic [WIDTH-1:0]       data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   contention_q, contention_d;
    logic                   decayed_q, decayed_d;
    logic [CYCLE_CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic [WIDTH-1:0]       resolved;
    logic                   multi_driver;

    wired_and_resolver #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_resolver (
        .pd_en_i        (pd_en),
        .pd_mask_i      (pd_mask),
        .bus_value_o    (resolved),
        .multi_driver_o (multi_driver)
    );

    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        decay_cnt_d   = decay_cnt_q;
        decay_hit_d   = decay_hit_q;
        data_out_d    = data_out_q;
        valid_d       = 1'b0;
        contention_d  = contention_q;
        decayed_d     = decayed_q;
        cycle_count_d = cycle_count_q;
        bus           = '1;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d   = ST_PRECHARGE;
                    pre_cnt_d = '0;
                end
            end
            ST_PRECHARGE: begin
                if (pre_cnt_q == PRE_LAST) begin
                    state_d     = ST_DISCHARGE;
                    pre_cnt_d   = '0;
                    decay_cnt_d = '0;
                    decay_hit_d = 1'b0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
                end
            end
            ST_DISCHARGE: begin
                bus = resolved;
                if (stall) begin
                    decay_cnt_d = decay_cnt_q + DECAY_CNT_W'(1);
                    // The stalled clock that reaches the limit forces the sample
                    if (decay_cnt_q == DECAY_LAST) begin
                        state_d     = ST_SAMPLE;
                        decay_hit_d = 1'b1;
                    end
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // A decayed cycle has lost its stored charge, so every line reads low
                bus           = decay_hit_q ? '0 : resolved;
                data_out_d    = decay_hit_q ? '0 : resolved;
                valid_d       = 1'b1;
                contention_d  = multi_driver;
                decayed_d     = decay_hit_q;
                cycle_count_d = sat_inc(cycle_count_q);
                pre_cnt_d     = '0;
                state_d       = run ? ST_PRECHARGE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pre_cnt_q     <= '0;
            decay_cnt_q   <= '0;
            decay_hit_q   <= 1'b0;
            data_out_q    <= '1;
            valid_q       <= 1'b0;
            contention_q  <= 1'b0;
            decayed_q     <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            decay_cnt_q   <= decay_cnt_d;
            decay_hit_q   <= decay_hit_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            contention_q  <= contention_d;
            decayed_q     <= decayed_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign phase       = state_q;
    assign data_out    = data_out_q;
    assign valid       = valid_q;
    assign contention  = contention_q;
    assign decayed     = decayed_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_dynamic_bus_sequencer.sv
// Self-checking bench for dynamic_bus_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a clock-level reference model.
module tb_dynamic_bus_sequencer;

    localparam int PRE   = 1;
    localparam int DECAY = 8;

    logic        clk;
    logic        reset;
    logic        run;
    logic        stall;
    logic [3:0]  pd_en;
    logic [31:0] pd_mask;
    logic [7:0]  bus;
    logic [1:0]  phase;
    logic [7:0]  data_out;
    logic        valid;
    logic        contention;
    logic        decayed;
    logic [15:0] cycle_count;

    dynamic_bus_sequencer #(
        .WIDTH        (8),
        .NSRC         (4),
        .PRE_CYCLES   (PRE),
        .DECAY_CYCLES (DECAY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .stall       (stall),
        .pd_en       (pd_en),
        .pd_mask     (pd_mask),
        .bus         (bus),
        .phase       (phase),
        .data_out    (data_out),
        .valid       (valid),
        .contention  (contention),
        .decayed     (decayed),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    // Reference model state: phase number, clocks spent in phase, latched results
    int          m_phase;
    int          m_pre;
    int          m_dec;
    bit          m_hit;
    bit          m_valid;
    bit          m_cont;
    bit          m_decayed;
    logic [7:0]  m_data;
    logic [15:0] m_count;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] mask;
        int          stall_n;
        logic [7:0]  exp_data;
        logic        exp_cont;
        logic        exp_dec;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_resolve(input logic [3:0] en, input logic [31:0] mask);
        logic [7:0] pulled;
        pulled = 8'h00;
        for (int i = 0; i < 4; i++)
            if (en[i]) pulled = pulled | mask[i*8 +: 8];
        return ~pulled;
    endfunction

    function automatic logic [7:0] ref_bus(input logic [3:0] en, input logic [31:0] mask);
        if (m_phase == 2) return ref_resolve(en, mask);
        if (m_phase == 3) return m_hit ? 8'h00 : ref_resolve(en, mask);
        return 8'hFF;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pre = 0; m_dec = 0; m_hit = 0;
        m_valid = 0; m_cont = 0; m_decayed = 0; m_data = 8'hFF; m_count = 16'h0000;
    endtask

    task automatic model_step(input logic r, input logic s, input logic [3:0] en, input logic [31:0] mask);
        m_valid = 0;
        case (m_phase)
            0: if (r) begin m_phase = 1; m_pre = 0; end
            1: begin
                m_pre++;
                if (m_pre >= PRE) begin m_phase = 2; m_dec = 0; m_hit = 0; end
            end
            2: begin
                if (!s) m_phase = 3;
                else begin
                    m_dec++;
                    if (m_dec >= DECAY) begin m_phase = 3; m_hit = 1; end
                end
            end
            default: begin
                m_valid   = 1;
                m_data    = m_hit ? 8'h00 : ref_resolve(en, mask);
                m_cont    = ($countones(en) > 1);
                m_decayed = m_hit;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                m_phase   = r ? 1 : 0;
                m_pre     = 0;
            end
        endcase
    endtask

    // One clock: drive inputs, check the live bus, step the model, check registered outputs
    task automatic tick(input logic r, input logic s, input logic [3:0] en, input logic [31:0] mask);
        run = r; stall = s; pd_en = en; pd_mask = mask;
        #1;
        check("bus", bus, ref_bus(en, mask));
        model_step(r, s, en, mask);
        @(posedge clk);
        @(negedge clk);
        check("phase", phase, m_phase);
        check("valid", valid, m_valid);
        check("data_out", data_out, m_data);
        check("contention", contention, m_cont);
        check("decayed", decayed, m_decayed);
        check("cycle_count", cycle_count, m_count);
        if (valid) begin
            txn_no++;
            $display("txn %0d data_out=%h contention=%b decayed=%b cycle_count=%0d",
                     txn_no, data_out, contention, decayed, cycle_count);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; stall = 1'b0; pd_en = '0; pd_mask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bus"}, bus, 8'hFF);
        check({tag, "_phase"}, phase, 2'd0);
        check({tag, "_data_out"}, data_out, 8'hFF);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_contention"}, contention, 1'b0);
        check({tag, "_decayed"}, decayed, 1'b0);
        check({tag, "_cycle_count"}, cycle_count, 16'h0000);
    endtask

    initial begin
        int left;
        int lat;
        int pre_phase;
        bit seen;
        logic [3:0]  ren;
        logic [31:0] rmask;
        int stall_pct;

        vecs[0] = '{4'b0001, 32'h0000000F, 0,  8'hF0, 1'b0, 1'b0, 4};
        vecs[1] = '{4'b0101, 32'h00800001, 0,  8'h7E, 1'b1, 1'b0, 4};
        vecs[2] = '{4'b0000, 32'hFFFFFFFF, 0,  8'hFF, 1'b0, 1'b0, 4};
        vecs[3] = '{4'b1111, 32'h01020408, 0,  8'hF0, 1'b1, 1'b0, 4};
        vecs[4] = '{4'b1000, 32'hAA000055, 0,  8'h55, 1'b0, 1'b0, 4};
        vecs[5] = '{4'b0010, 32'h0000FF00, 0,  8'h00, 1'b0, 1'b0, 4};
        vecs[6] = '{4'b0001, 32'h0000000F, 7,  8'hF0, 1'b0, 1'b0, 11};
        vecs[7] = '{4'b0101, 32'h00800001, 20, 8'h00, 1'b1, 1'b1, 11};

        reset = 1'b1; run = 1'b0; stall = 1'b0; pd_en = '0; pd_mask = '0;
        do_reset();
        check_reset_values("reset_idle");
        repeat (3) tick(1'b0, 1'b0, 4'b0001, 32'h0000000F);

        // Directed vectors: run for one clock only, so each cycle must still complete
        for (int v = 0; v < 8; v++) begin
            left = vecs[v].stall_n;
            seen = 0;
            lat  = 0;
            for (int t = 1; t <= 40 && !seen; t++) begin
                pre_phase = m_phase;
                tick(t == 1, left > 0, vecs[v].en, vecs[v].mask);
                if (pre_phase == 2 && left > 0) left--;
                if (valid === 1'b1) begin
                    seen = 1;
                    lat  = t;
                end
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL vec%0d_valid_timeout actual=none required=pulse", v);
            end else begin
                check($sformatf("vec%0d_data", v), data_out, vecs[v].exp_data);
                check($sformatf("vec%0d_contention", v), contention, vecs[v].exp_cont);
                check($sformatf("vec%0d_decayed", v), decayed, vecs[v].exp_dec);
                check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            end
            tick(1'b0, 1'b0, 4'b0000, 32'h0);
        end

        // Reset after sticky contention/decayed were set must clear them
        do_reset();
        check_reset_values("reset_after_use");

        // Mid-cycle reset during DISCHARGE: cycle discarded, no valid pulse
        tick(1'b1, 1'b0, 4'b0001, 32'h0000000F);
        tick(1'b1, 1'b0, 4'b0001, 32'h0000000F);
        check("midreset_in_discharge", phase, 2'd2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_phase", phase, 2'd0);
        check("midreset_valid", valid, 1'b0);
        check("midreset_cycle_count", cycle_count, 16'h0000);
        reset = 1'b0;
        model_reset();
        repeat (4) tick(1'b0, 1'b0, 4'b0001, 32'h0000000F);

        // Randomized traffic against the model, alternating light and heavy stall
        for (int i = 0; i < 600; i++) begin
            stall_pct = ((i / 100) % 2 == 1) ? 85 : 25;
            ren   = 4'($urandom_range(0, 15));
            rmask = $urandom;
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 99) < stall_pct, ren, rmask);
        end
        repeat (20) tick(1'b0, 1'b0, 4'b0000, 32'h0);

        // Saturation: preload the counter just below its ceiling, then keep running
        do_reset();
        force dut.cycle_count_q = 16'hFFFD;
        m_count = 16'hFFFD;
        repeat (2) tick(1'b0, 1'b0, 4'b0000, 32'h0);
        release dut.cycle_count_q;
        for (int i = 0; i < 24; i++) begin
            ren   = 4'($urandom_range(0, 15));
            rmask = $urandom;
            tick(1'b1, 1'b0, ren, rmask);
        end
        repeat (6) tick(1'b0, 1'b0, 4'b0000, 32'h0);
        check("cycle_count_saturated", cycle_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dynamic_bus_sequencer.md
DYNAMIC_BUS_SEQUENCER -- requirements
Module: dynamic_bus_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bus lines.
REQ-002 SHALL have parameter NSRC, default 4: number of pull-down sources.
REQ-003 SHALL have parameter PRE_CYCLES, default 1, range 1..15: length of the precharge phase in clocks.
REQ-004 SHALL have parameter DECAY_CYCLES, default 8, range 1..255: maximum discharge-phase stall before stored charge is lost.
REQ-005 SHALL have port clk, input, 1: single system clock, rising-edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port run, input, 1: level request to keep issuing bus cycles.
REQ-008 SHALL have port stall, input, 1: extends the discharge phase.
REQ-009 SHALL have port pd_en, input, NSRC: per-source enable.
REQ-010 SHALL have port pd_mask, input, NSRC*WIDTH: source i occupies bits [i*WIDTH +: WIDTH]; 1 = pull that line low.
REQ-011 SHALL have port bus, output, WIDTH: present dynamic bus value.
REQ-012 SHALL have port phase, output, 2: current state encoding.
REQ-013 SHALL have port data_out, output, WIDTH: value latched at sample.
REQ-014 SHALL have port valid, output, 1: single-cycle pulse when data_out updates.
REQ-015 SHALL have port contention, output, 1: more than one source was enabled at sample.
REQ-016 SHALL have port decayed, output, 1: the last sample was forced by charge loss.
REQ-017 SHALL have port cycle_count, output, 16: completed bus cycles, saturating.

Function
REQ-018 SHALL implement the states IDLE=0, PRECHARGE=1, DISCHARGE=2, SAMPLE=3, presented on phase.
REQ-019 IDLE: bus SHALL equal all-ones (pullup behaviour); run=1 SHALL cause a transition to PRECHARGE on the next clock.
REQ-020 PRECHARGE: bus SHALL equal all-ones; the state SHALL last exactly PRE_CYCLES clocks, then go to DISCHARGE.
REQ-021 DISCHARGE: bus SHALL equal ~(OR over i of (pd_en[i] ? pd_mask[i] : 0)), i.e. a wired-AND of the pull-downs.
REQ-022 DISCHARGE: with stall=0 the state SHALL last 1 clock, then go to SAMPLE; each clock with stall=1 SHALL remain in DISCHARGE and increment the decay counter.
REQ-023 When the decay counter reaches DECAY_CYCLES, the state SHALL go to SAMPLE regardless of stall, and decayed SHALL be set for that sample.
REQ-024 SAMPLE: the sequencer SHALL latch data_out, pulse valid for 1 clock, and increment cycle_count, saturating at 16'hFFFF.
REQ-025 SAMPLE: in the normal case data_out SHALL equal the bus value computed from the sources in the same clock.
REQ-026 SAMPLE: in the decayed case data_out SHALL equal all-zeros (charge lost).
REQ-027 After SAMPLE the state SHALL go to PRECHARGE if run=1, else to IDLE.
REQ-028 Dropping run SHALL NOT abort a cycle in progress; the cycle SHALL complete through SAMPLE.
REQ-029 contention SHALL be registered at SAMPLE as (popcount(pd_en) > 1) and held until the next SAMPLE.
REQ-030 decayed SHALL be registered at SAMPLE and held until the next SAMPLE.
REQ-031 Minimum cycle latency from run asserted to valid SHALL be PRE_CYCLES+3 clocks, with no stall.
REQ-032 If stall=1 coincides with the decay limit, decay SHALL win.

Reset
REQ-033 reset SHALL have priority over all inputs in every state.
REQ-034 On reset the state SHALL be IDLE and bus SHALL be all-ones.
REQ-035 On reset data_out SHALL be all-ones, and valid, contention and decayed SHALL be 0.
REQ-036 On reset cycle_count, the precharge counter and the decay counter SHALL be 0.
REQ-037 A reset asserted mid-cycle SHALL discard the cycle and produce no valid pulse.

Structure
REQ-038 A shared package SHALL hold the state encoding constants and the counter widths (4-bit precharge, 8-bit decay, 16-bit cycle).
REQ-039 The combinational wired-AND merge SHALL be a sub-module, wired_and_resolver, with parameters WIDTH and NSRC.
REQ-040 The FSM and counters SHALL be in the top module.

Verification
REQ-041 Reset and idle: after reset with run=0 -> bus=8'hFF, phase=0, data_out=8'hFF, cycle_count=0.
REQ-042 Single cycle: run=1, pd_en=4'b0001, src0 mask=8'h0F, PRE_CYCLES=1 -> valid at clock 4, data_out=8'hF0, contention=0.
REQ-043 Contention: src0=8'h01 and src2=8'h80 enabled -> data_out=8'h7E, contention=1.
REQ-044 Decay: stall held 20 clocks, DECAY_CYCLES=8 -> sample after 8 stalled clocks, data_out=8'h00, decayed=1.
REQ-045 Mid-cycle reset: reset during DISCHARGE -> no valid pulse, phase=0, cycle_count unchanged at 0.
REQ-046 Saturation: cycle_count preloaded near 16'hFFFF and run held -> cycle_count stays at 16'hFFFF.
